// File: rtl/pipe_pkg.sv
// Shared constants for the generic inter-stage pipeline register.
// Exception code 0 means "no exception".
package pipe_pkg;

    localparam int          EXC_NONE         = 0;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
    localparam int          OCC_W            = 2;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry {valid, pc, data, exc}.
// Control priority: clr_all (valid, data and exc cleared, pc kept) > load > clr_valid.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int          DATA_W   = 64,
    parameter int          EXC_W    = 5,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clr_valid,
    input  logic              clr_all,
    input  logic              ld_valid,
    input  logic [31:0]       ld_pc,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [EXC_W-1:0]  ld_exc,
    output logic              valid,
    output logic              valid_nxt,
    output logic [31:0]       pc,
    output logic [DATA_W-1:0] data,
    output logic [EXC_W-1:0]  exc
);

    logic              valid_q, valid_d;
    logic [31:0]       pc_q, pc_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [EXC_W-1:0]  exc_q, exc_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        data_d  = data_q;
        exc_d   = exc_q;
        if (clr_all) begin
            valid_d = 1'b0;
            data_d  = '0;
            exc_d   = '0;
        end else if (load) begin
            valid_d = ld_valid;
            pc_d    = ld_pc;
            data_d  = ld_data;
            exc_d   = ld_exc;
        end else if (clr_valid) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            data_q  <= '0;
            exc_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
            exc_q   <= exc_d;
        end
    end

    assign valid     = valid_q;
    assign valid_nxt = valid_d;
    assign pc        = pc_q;
    assign data      = data_q;
    assign exc       = exc_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage register with valid/ready handshake, optional skid entry,
// hazard bubble insertion and flush. The main slot always holds the older beat.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int          DATA_W   = 64,
    parameter int          EXC_W    = 5,
    parameter int          SKID     = 1,
    parameter int          EXC_KILL = 1,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              bubble,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [EXC_W-1:0]  out_exc,
    output logic [OCC_W-1:0]  occupancy
);

    logic              accept, drain, main_free;
    logic [DATA_W-1:0] in_data_k;

    logic              main_load, main_clr_valid, main_clr_all, main_valid_nxt;
    logic              main_ld_valid;
    logic [31:0]       main_ld_pc;
    logic [DATA_W-1:0] main_ld_data;
    logic [EXC_W-1:0]  main_ld_exc;

    logic              skid_load, skid_clr_valid, skid_clr_all;
    logic              skid_valid, skid_valid_nxt;
    logic [31:0]       skid_pc;
    logic [DATA_W-1:0] skid_data;
    logic [EXC_W-1:0]  skid_exc;

    logic [OCC_W-1:0]  occupancy_q, occupancy_d;

    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign main_free = !out_valid || drain;
    assign in_data_k = (EXC_KILL != 0 && in_exc != EXC_W'(EXC_NONE)) ? '0 : in_data;

    always_comb begin
        main_load      = 1'b0;
        main_clr_valid = 1'b0;
        main_clr_all   = 1'b0;
        main_ld_valid  = 1'b1;
        main_ld_pc     = in_pc;
        main_ld_data   = in_data_k;
        main_ld_exc    = in_exc;
        skid_load      = 1'b0;
        skid_clr_valid = 1'b0;
        skid_clr_all   = 1'b0;
        if (flush) begin
            main_clr_all = 1'b1;
            skid_clr_all = 1'b1;
        end else if (bubble && main_free && !skid_valid) begin
            main_load     = 1'b1;
            main_ld_valid = 1'b0;
            main_ld_data  = '0;
            main_ld_exc   = '0;
        end else if (drain && skid_valid) begin
            // Promote the skid beat even under a bubble so a consumed beat is never re-presented.
            main_load      = 1'b1;
            main_ld_pc     = skid_pc;
            main_ld_data   = skid_data;
            main_ld_exc    = skid_exc;
            skid_clr_valid = 1'b1;
        end else if (!bubble) begin
            if (main_free) begin
                if (accept) begin
                    main_load = 1'b1;
                end else if (drain) begin
                    main_clr_valid = 1'b1;
                end
            end else if (accept) begin
                skid_load = 1'b1;
            end
        end
    end

    pipe_slot #(
        .DATA_W   (DATA_W),
        .EXC_W    (EXC_W),
        .RESET_PC (RESET_PC)
    ) u_main (
        .clk       (clk),
        .reset     (reset),
        .load      (main_load),
        .clr_valid (main_clr_valid),
        .clr_all   (main_clr_all),
        .ld_valid  (main_ld_valid),
        .ld_pc     (main_ld_pc),
        .ld_data   (main_ld_data),
        .ld_exc    (main_ld_exc),
        .valid     (out_valid),
        .valid_nxt (main_valid_nxt),
        .pc        (out_pc),
        .data      (out_data),
        .exc       (out_exc)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(
                .DATA_W   (DATA_W),
                .EXC_W    (EXC_W),
                .RESET_PC (RESET_PC)
            ) u_skid (
                .clk       (clk),
                .reset     (reset),
                .load      (skid_load),
                .clr_valid (skid_clr_valid),
                .clr_all   (skid_clr_all),
                .ld_valid  (1'b1),
                .ld_pc     (in_pc),
                .ld_data   (in_data_k),
                .ld_exc    (in_exc),
                .valid     (skid_valid),
                .valid_nxt (skid_valid_nxt),
                .pc        (skid_pc),
                .data      (skid_data),
                .exc       (skid_exc)
            );
            // Registered-only ready breaks the combinational out_ready -> in_ready path.
            assign in_ready = !skid_valid && !bubble && !flush;
        end else begin : g_noskid
            assign skid_valid     = 1'b0;
            assign skid_valid_nxt = 1'b0;
            assign skid_pc        = '0;
            assign skid_data      = '0;
            assign skid_exc       = '0;
            assign in_ready       = (!out_valid || out_ready) && !bubble && !flush;
        end
    endgenerate

    assign occupancy_d = OCC_W'(main_valid_nxt) + OCC_W'(skid_valid_nxt);

    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy_q <= '0;
        end else begin
            occupancy_q <= occupancy_d;
        end
    end

    assign occupancy = occupancy_q;

endmodule
